acc_traffic_model: RTL and testbench

- Parametrised dummy accelerator that models accelerator traffic in the fifo_controller acc_unit slot.
- Consumes a batch of serialization_ratio input beats and folds it into one result word using a selectable mode.
- Holds each completed job for wait_cycles, then emits deserialization_ratio output beats.
- Unlike the single-job dummy, up to MAX_JOBS jobs are in flight at once: ingest, wait and egress overlap, and each job's wait timer runs independently.

---
 rtl/acc_traffic_pkg.sv | 58 +++++
 rtl/acc_job_queue.sv | 102 ++++++++++
 rtl/acc_traffic_model.sv | 172 +++++++++++++++++
 tb/tb_acc_traffic_model.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_traffic_pkg.sv
// Shared types and helpers for the accelerator traffic model: fold modes,
// ingest FSM states, the queued job record and the per-beat fold function.
package acc_traffic_pkg;

    localparam int JOB_DATA_W  = 64;
    localparam int JOB_RATIO_W = 16;
    localparam int JOB_WAIT_W  = 14;

    typedef enum logic [1:0] {
        M_LAST = 2'd0,
        M_XOR  = 2'd1,
        M_SUM  = 2'd2,
        M_INCR = 2'd3
    } mode_t;

    typedef enum logic {
        I_IDLE    = 1'b0,
        I_COLLECT = 1'b1
    } ingest_state_t;

    typedef struct packed {
        logic [JOB_DATA_W-1:0]  result;
        logic [JOB_RATIO_W-1:0] deser;
        mode_t                  mode;
        logic [JOB_WAIT_W-1:0]  timer;
    } job_t;

    // A ratio of zero behaves as a ratio of one.
    function automatic logic [JOB_RATIO_W-1:0] eff_ratio(input logic [JOB_RATIO_W-1:0] r);
        logic [JOB_RATIO_W-1:0] res;
        if (r == {JOB_RATIO_W{1'b0}}) begin
            res = {{(JOB_RATIO_W-1){1'b0}}, 1'b1};
        end else begin
            res = r;
        end
        return res;
    endfunction

    function automatic logic [JOB_DATA_W-1:0] fold_beat(
        input mode_t                 m,
        input logic                  first,
        input logic [JOB_DATA_W-1:0] acc,
        input logic [JOB_DATA_W-1:0] din
    );
        logic [JOB_DATA_W-1:0] res;
        if (first) begin
            res = din;
        end else begin
            case (m)
                M_XOR:   res = acc ^ din;
                M_SUM:   res = acc + din;
                default: res = din;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/acc_job_queue.sv
// In-order queue of completed jobs; every resident entry counts its own wait
// timer down in parallel, and the head is eligible once its timer reaches zero.
module acc_job_queue
    import acc_traffic_pkg::*;
#(
    parameter int MAX_JOBS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  job_t                        push_job_i,
    input  logic                        pop_i,
    output job_t                        head_o,
    output logic                        head_valid_o,
    output logic                        head_eligible_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(MAX_JOBS):0]   count_o
);

    localparam int PTR_W = $clog2(MAX_JOBS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_JOBS);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [JOB_WAIT_W-1:0] TMR_ZERO = {JOB_WAIT_W{1'b0}};
    localparam logic [JOB_WAIT_W-1:0] TMR_ONE  = {{(JOB_WAIT_W-1){1'b0}}, 1'b1};

    job_t                entry_q [MAX_JOBS];
    job_t                entry_d [MAX_JOBS];
    logic [MAX_JOBS-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push_ok_s, pop_ok_s;

    assign head_o          = entry_q[rd_ptr_q];
    assign head_valid_o    = valid_q[rd_ptr_q];
    assign head_eligible_o = valid_q[rd_ptr_q] && (entry_q[rd_ptr_q].timer == TMR_ZERO);
    assign full_o          = (count_q == FULL_CNT);
    assign empty_o         = (count_q == {CNT_W{1'b0}});
    assign count_o         = count_q;

    // A full queue refuses pushes even when the head pops in the same cycle.
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && head_valid_o;

    // Next-state: parallel timer countdown, then pop and push bookkeeping.
    always_comb begin
        entry_d  = entry_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < MAX_JOBS; i++) begin
            if (valid_q[i] && (entry_q[i].timer != TMR_ZERO)) begin
                entry_d[i].timer = entry_q[i].timer - TMR_ONE;
            end else begin
                entry_d[i].timer = entry_q[i].timer;
            end
        end
        if (pop_ok_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s) begin
            entry_d[wr_ptr_q] = push_job_i;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Queue storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_JOBS; i++) begin
                entry_q[i] <= '{result: {JOB_DATA_W{1'b0}}, deser: {JOB_RATIO_W{1'b0}},
                                mode: M_LAST, timer: TMR_ZERO};
            end
            valid_q  <= {MAX_JOBS{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            entry_q  <= entry_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/acc_traffic_model.sv
// Dummy accelerator: folds batches of input beats into one result per job,
// queues up to MAX_JOBS delayed jobs and replays each as a burst of output beats.
module acc_traffic_model
    import acc_traffic_pkg::*;
#(
    parameter int DATA_W   = JOB_DATA_W,
    parameter int MAX_JOBS = 4,
    parameter int RATIO_W  = JOB_RATIO_W,
    parameter int WAIT_W   = JOB_WAIT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [RATIO_W-1:0]  serialization_ratio,
    input  logic [RATIO_W-1:0]  deserialization_ratio,
    input  logic [WAIT_W-1:0]   wait_cycles,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                busy,
    output logic [15:0]         jobs_done
);

    localparam logic [RATIO_W-1:0] R_ONE  = {{(RATIO_W-1){1'b0}}, 1'b1};
    localparam logic [RATIO_W-1:0] R_ZERO = {RATIO_W{1'b0}};

    ingest_state_t       state_q, state_d;
    logic [RATIO_W-1:0]  ser_q, ser_d;
    logic [RATIO_W-1:0]  deser_q, deser_d;
    mode_t               mode_q, mode_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [RATIO_W-1:0]  in_beat_q, in_beat_d;
    logic [RATIO_W-1:0]  out_beat_q, out_beat_d;
    logic [15:0]         jobs_done_q, jobs_done_d;

    logic                accept_s, push_s, pop_s;
    logic [DATA_W-1:0]   fold_s;
    job_t                push_job_s, head_s;
    logic                head_valid_s, head_eligible_s, q_full_s, q_empty_s;
    logic [$clog2(MAX_JOBS):0] q_count_s;
    logic                out_valid_s;
    logic [DATA_W-1:0]   out_data_s;

    acc_job_queue #(.MAX_JOBS(MAX_JOBS)) u_queue (
        .clk             (clk),
        .rst_n           (rst_n),
        .push_i          (push_s),
        .push_job_i      (push_job_s),
        .pop_i           (pop_s),
        .head_o          (head_s),
        .head_valid_o    (head_valid_s),
        .head_eligible_o (head_eligible_s),
        .full_o          (q_full_s),
        .empty_o         (q_empty_s),
        .count_o         (q_count_s)
    );

    assign in_ready  = (state_q == I_COLLECT) && !q_full_s;
    assign accept_s  = in_valid && in_ready;
    assign fold_s    = fold_beat(mode_q, (in_beat_q == R_ZERO), acc_q, in_data);
    assign push_job_s = '{result: fold_s, deser: deser_q, mode: mode_q, timer: wait_q};

    // Ingest FSM: latch job parameters on start, fold beats, push on the last one.
    always_comb begin
        state_d   = state_q;
        ser_d     = ser_q;
        deser_d   = deser_q;
        mode_d    = mode_q;
        wait_d    = wait_q;
        acc_d     = acc_q;
        in_beat_d = in_beat_q;
        push_s    = 1'b0;
        case (state_q)
            I_IDLE: begin
                if (enable && !q_full_s) begin
                    state_d   = I_COLLECT;
                    ser_d     = eff_ratio(serialization_ratio);
                    deser_d   = eff_ratio(deserialization_ratio);
                    mode_d    = mode_t'(mode);
                    wait_d    = wait_cycles;
                    in_beat_d = R_ZERO;
                end else begin
                    state_d = I_IDLE;
                end
            end
            I_COLLECT: begin
                if (accept_s) begin
                    acc_d = fold_s;
                    if (in_beat_q == (ser_q - R_ONE)) begin
                        push_s    = 1'b1;
                        state_d   = I_IDLE;
                        in_beat_d = R_ZERO;
                    end else begin
                        in_beat_d = in_beat_q + R_ONE;
                    end
                end else begin
                    state_d = I_COLLECT;
                end
            end
            default: state_d = I_IDLE;
        endcase
    end

    assign out_valid_s = head_eligible_s;

    // Egress data: mode 3 adds the beat index to the result.
    always_comb begin
        out_data_s = {DATA_W{1'b0}};
        if (out_valid_s) begin
            case (head_s.mode)
                M_INCR:  out_data_s = head_s.result + DATA_W'(out_beat_q);
                default: out_data_s = head_s.result;
            endcase
        end else begin
            out_data_s = {DATA_W{1'b0}};
        end
    end

    // Egress beat counting, head pop and completed-job counter.
    always_comb begin
        out_beat_d  = out_beat_q;
        jobs_done_d = jobs_done_q;
        pop_s       = 1'b0;
        if (out_valid_s && out_ready) begin
            if (out_beat_q == (head_s.deser - R_ONE)) begin
                pop_s       = 1'b1;
                out_beat_d  = R_ZERO;
                jobs_done_d = jobs_done_q + 16'd1;
            end else begin
                out_beat_d = out_beat_q + R_ONE;
            end
        end else begin
            out_beat_d = out_beat_q;
        end
    end

    // Ingest and egress state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= I_IDLE;
            ser_q       <= R_ONE;
            deser_q     <= R_ONE;
            mode_q      <= M_LAST;
            wait_q      <= {WAIT_W{1'b0}};
            acc_q       <= {DATA_W{1'b0}};
            in_beat_q   <= R_ZERO;
            out_beat_q  <= R_ZERO;
            jobs_done_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            ser_q       <= ser_d;
            deser_q     <= deser_d;
            mode_q      <= mode_d;
            wait_q      <= wait_d;
            acc_q       <= acc_d;
            in_beat_q   <= in_beat_d;
            out_beat_q  <= out_beat_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign busy      = (state_q == I_COLLECT) || !q_empty_s;
    assign jobs_done = jobs_done_q;

endmodule

// File: tb/tb_acc_traffic_model.sv
// Directed bench for acc_traffic_model: expected output beats are queued as
// stimulus is driven and compared whenever the DUT hands a beat over.
module tb_acc_traffic_model;
    import acc_traffic_pkg::*;

    localparam int DATA_W   = 64;
    localparam int RATIO_W  = 16;
    localparam int WAIT_W   = 14;
    localparam int MAX_JOBS = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic [RATIO_W-1:0]  ser = 16'd1;
    logic [RATIO_W-1:0]  deser = 16'd1;
    logic [WAIT_W-1:0]   wait_c = 14'd0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data = 64'd0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DATA_W-1:0]   out_data;
    logic                busy;
    logic [15:0]         jobs_done;

    always #5 clk = ~clk;

    acc_traffic_model #(
        .DATA_W(DATA_W), .MAX_JOBS(MAX_JOBS), .RATIO_W(RATIO_W), .WAIT_W(WAIT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .serialization_ratio(ser), .deserialization_ratio(deser), .wait_cycles(wait_c),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .jobs_done(jobs_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int first_valid_cyc = -1;
    int exp_jobs = 0;
    bit in_hs = 1'b0;
    bit stall_pend = 1'b0;
    logic [DATA_W-1:0] stall_data = 64'd0;
    logic [DATA_W-1:0] exp_q[$];
    int beat_cyc_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample on the falling edge, score beats, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        in_hs = in_valid && in_ready;
        if (in_hs) hs_cyc = cyc;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_pend) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", out_data, stall_data);
        end
        if (out_valid && out_ready) begin
            beat_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat: observed 0x%0h expected no beat", out_data);
                end
            end else begin
                check("beat", out_data, exp_q.pop_front());
            end
        end
        stall_pend = out_valid && !out_ready;
        stall_data = out_data;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        in_hs    = 1'b0;
        for (int n = 0; n < 200 && !in_hs; n++) tick();
        check("in_accept", 64'(in_hs), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 1'b0;
        for (int n = 0; n < 500 && !idle; n++) begin
            tick();
            idle = !busy && !out_valid && (exp_q.size() == 0);
        end
        check({tag, "_idle"}, 64'(idle), 64'd1);
        check({tag, "_jobs_done"}, 64'(jobs_done), 64'(exp_jobs));
    endtask

    initial begin
        int last_in, ta, tb_c, hs_cnt, rel;

        // Reset state
        tick(); tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_jobs_done", 64'(jobs_done), 64'd0);
        rst_n = 1'b1;
        tick();

        // XOR fold, 3 in / 2 out, wait 5; enable dropped mid-collect
        mode = 2'd1; ser = 16'd3; deser = 16'd2; wait_c = 14'd5;
        out_ready = 1'b1; enable = 1'b1; first_valid_cyc = -1;
        exp_q.push_back(64'h7); exp_q.push_back(64'h7); exp_jobs = 1;
        send_beat(64'h1);
        enable = 1'b0;
        send_beat(64'h2);
        send_beat(64'h4);
        last_in = hs_cyc;
        wait_idle("t1");
        check("t1_latency", 64'(first_valid_cyc - last_in), 64'd6);

        // Incrementing egress under a toggling out_ready
        mode = 2'd3; ser = 16'd1; deser = 16'd4; wait_c = 14'd0;
        out_ready = 1'b0; enable = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(64'h10 + 64'(k));
        exp_jobs = 2;
        send_beat(64'h10);
        enable = 1'b0;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        wait_idle("t2");

        // Queue full: fifth job held off until the queue drains
        mode = 2'd0; ser = 16'd1; deser = 16'd1; wait_c = 14'd0;
        out_ready = 1'b0; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(64'hA0 + 64'(k));
            send_beat(64'hA0 + 64'(k));
        end
        exp_q.push_back(64'hA4); exp_jobs = 7;
        in_data = 64'hA4; in_valid = 1'b1; hs_cnt = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (in_hs) hs_cnt++;
        end
        check("t3_full_in_ready", 64'(in_ready), 64'd0);
        check("t3_full_no_accept", 64'(hs_cnt), 64'd0);
        check("t3_full_busy", 64'(busy), 64'd1);
        check("t3_head_valid", 64'(out_valid), 64'd1);
        check("t3_head_data", out_data, 64'hA0);
        out_ready = 1'b1;
        send_beat(64'hA4);
        enable = 1'b0;
        wait_idle("t3");

        // Overlapping jobs: second job's timer runs while the first is stalled
        mode = 2'd0; ser = 16'd1; deser = 16'd2; wait_c = 14'd10;
        out_ready = 1'b0; enable = 1'b1;
        exp_q.push_back(64'hAA); exp_q.push_back(64'hAA);
        exp_q.push_back(64'hBB); exp_q.push_back(64'hBB);
        exp_jobs = 9;
        send_beat(64'hAA); ta = hs_cyc;
        send_beat(64'hBB); tb_c = hs_cyc;
        enable = 1'b0;
        check("t4_push_gap", 64'(tb_c - ta), 64'd2);
        repeat (30) tick();
        beat_cyc_q.delete();
        rel = cyc;
        out_ready = 1'b1;
        wait_idle("t4");
        check("t4_beats", 64'(beat_cyc_q.size()), 64'd4);
        if (beat_cyc_q.size() == 4) begin
            check("t4_a_first", 64'(beat_cyc_q[0] - rel), 64'd0);
            check("t4_b_follows_pop", 64'(beat_cyc_q[2] - beat_cyc_q[1]), 64'd1);
        end

        // Zero ratios treated as one; sum fold wraps
        mode = 2'd2; ser = 16'd0; deser = 16'd0; wait_c = 14'd0;
        out_ready = 1'b1; enable = 1'b1;
        exp_q.push_back({DATA_W{1'b1}}); exp_q.push_back(64'h1); exp_q.push_back(64'h0);
        exp_jobs = 12;
        send_beat({DATA_W{1'b1}});
        send_beat(64'h1);
        ser = 16'd2;
        send_beat({DATA_W{1'b1}});
        enable = 1'b0;
        send_beat(64'h1);
        wait_idle("t5");

        // Reset during egress of job 2 of 3
        mode = 2'd0; ser = 16'd1; deser = 16'd4; wait_c = 14'd0;
        out_ready = 1'b0; enable = 1'b1;
        send_beat(64'hC1);
        send_beat(64'hC2);
        send_beat(64'hC3);
        enable = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back(64'hC1);
        exp_q.push_back(64'hC2); exp_q.push_back(64'hC2);
        exp_jobs = 13;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
        check("t6_pre_jobs_done", 64'(jobs_done), 64'(exp_jobs));
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_out_data", out_data, 64'd0);
        check("t6_rst_in_ready", 64'(in_ready), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_jobs_done", 64'(jobs_done), 64'd0);
        exp_jobs = 0;
        stall_pend = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        beat_cyc_q.delete();
        repeat (20) tick();
        check("t6_no_residual", 64'(beat_cyc_q.size()), 64'd0);
        check("t6_jobs_done", 64'(jobs_done), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
